// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Registered WIDTH-bit adder: {carry,sum} = a + b + cin, one clock of latency.
//   A new operand set is accepted on every rising edge that has in_valid=1.
//   There is no stall path, so throughput is one result per clock.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   a, b       in   WIDTH  unsigned addends
//   cin        in   1      carry-in
//   in_valid   in   1      sample a/b/cin on this edge
//   sum        out  WIDTH  registered low WIDTH bits of a+b+cin
//   carry      out  1      registered bit WIDTH of a+b+cin (wrap flag)
//   out_valid  out  1      high for the one cycle after an accepted input
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int unsigned WIDTH = 1          // legal range 1..64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);

    // Ripple chain built from 1-bit full-adder cells. chain[i] is the carry
    // into bit i; chain[WIDTH] is the carry-out. The chain is WIDTH+1 bits
    // wide, so the carry is never lost to truncation.
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] sum_bits;

    assign chain[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic p;
        assign p             = a[i] ^ b[i];
        assign sum_bits[i]   = p ^ chain[i];
        assign chain[i+1]    = (a[i] & b[i]) | (chain[i] & p);
    end

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             carry_d, carry_q;
    logic             out_valid_d, out_valid_q;

    // The result registers load only when in_valid is high. With in_valid
    // low the operands never reach the flops, so X or Z on a/b/cin during
    // idle cycles cannot disturb the held result.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum_bits;
            carry_d     = chain[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    // Reset wins over in_valid. An input that collides with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs come straight from flops. There is no input-to-output comb path.
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, cin;
    logic [0:0]  a1, b1;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic [0:0]  s1;  logic c1, v1;
    logic [7:0]  s8;  logic c8, v8;
    logic [15:0] s16; logic c16, v16;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin), .in_valid(in_valid),
        .sum(s1), .carry(c1), .out_valid(v1));
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin), .in_valid(in_valid),
        .sum(s8), .carry(c8), .out_valid(v8));
    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin), .in_valid(in_valid),
        .sum(s16), .carry(c16), .out_valid(v16));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    // Plain integer arithmetic: total = a+b+cin, then sum = total mod 2^W
    // and carry = total / 2^W. The model holds its result on idle cycles and
    // clears it on reset.
    longint m_sum1, m_sum8, m_sum16;
    longint m_c1, m_c8, m_c16;
    longint m_v;

    function automatic longint add_total(input longint x, input longint y, input longint ci);
        return x + y + ci;
    endfunction

    always @(posedge clk) begin
        longint t1, t8, t16;
        if (rst) begin
            m_sum1 = 0; m_sum8 = 0; m_sum16 = 0;
            m_c1 = 0;   m_c8 = 0;   m_c16 = 0;
            m_v = 0;
        end else begin
            if (in_valid) begin
                t1  = add_total(longint'(a1),  longint'(b1),  longint'(cin));
                t8  = add_total(longint'(a8),  longint'(b8),  longint'(cin));
                t16 = add_total(longint'(a16), longint'(b16), longint'(cin));
                m_sum1  = t1  % 2;      m_c1  = t1  / 2;
                m_sum8  = t8  % 256;    m_c8  = t8  / 256;
                m_sum16 = t16 % 65536;  m_c16 = t16 / 65536;
            end
            m_v = in_valid ? 1 : 0;
        end
    end

    // Compare process: every cycle, just after the edge, all outputs vs model.
    bit cmp_en = 1'b0;
    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk("w1.sum",   64'(s1),  64'(m_sum1));
            chk("w1.carry", 64'(c1),  64'(m_c1));
            chk("w1.valid", 64'(v1),  64'(m_v));
            chk("w8.sum",   64'(s8),  64'(m_sum8));
            chk("w8.carry", 64'(c8),  64'(m_c8));
            chk("w8.valid", 64'(v8),  64'(m_v));
            chk("w16.sum",  64'(s16), 64'(m_sum16));
            chk("w16.carry",64'(c16), 64'(m_c16));
            chk("w16.valid",64'(v16), 64'(m_v));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic vld, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
        rst = r; in_valid = vld; cin = ci;
        a1 = a[0:0];  b1 = b[0:0];
        a8 = a[7:0];  b8 = b[7:0];
        a16 = a;      b16 = b;
    endtask

    // Advance one edge and land 3 time units after it.
    task automatic tick;
        @(posedge clk);
        #3;
    endtask

    logic [7:0] tt_sum, tt_carry;

    initial begin
        drive(1'b1, 1'b1, 16'd1, 16'd1, 1'b1);
        @(posedge clk); #3;
        cmp_en = 1'b1;

        // Reset held with live inputs: everything reads zero.
        tick;
        chk("rst.sum",   64'(s1), 64'd0);
        chk("rst.carry", 64'(c1), 64'd0);
        chk("rst.valid", 64'(v1), 64'd0);

        // First accepted input after release: 1+1+1.
        drive(1'b0, 1'b1, 16'd1, 16'd1, 1'b1);
        tick;
        chk("post_rst.w1.sum",   64'(s1), 64'd1);
        chk("post_rst.w1.carry", 64'(c1), 64'd1);
        chk("post_rst.w1.valid", 64'(v1), 64'd1);
        chk("post_rst.w8.sum",   64'(s8), 64'd3);

        // Exhaustive 1-bit truth table, {a,b,cin} = i.
        tt_sum   = 8'b1001_0110;   // bit i = expected sum for i
        tt_carry = 8'b1110_1000;   // bit i = expected carry for i
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(1'b0, 1'b1, {15'd0, v[2]}, {15'd0, v[1]}, v[0]);
            tick;
            chk($sformatf("tt%0d.sum", i),   64'(s1), 64'(tt_sum[i]));
            chk($sformatf("tt%0d.carry", i), 64'(c1), 64'(tt_carry[i]));
            chk($sformatf("tt%0d.valid", i), 64'(v1), 64'd1);
        end

        // Hold: accept 1+0+0, then idle with toggling inputs.
        drive(1'b0, 1'b1, 16'd1, 16'd0, 1'b0);
        tick;
        chk("hold.accept.sum", 64'(s1), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'(i));
            tick;
            chk($sformatf("hold%0d.sum", i),   64'(s1), 64'd1);
            chk($sformatf("hold%0d.carry", i), 64'(c1), 64'd0);
            chk($sformatf("hold%0d.valid", i), 64'(v1), 64'd0);
        end

        // 8-bit wrap cases.
        drive(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
        tick;
        chk("wrap1.sum",   64'(s8), 64'h00);
        chk("wrap1.carry", 64'(c8), 64'd1);
        drive(1'b0, 1'b1, 16'h00FF, 16'h00FF, 1'b1);
        tick;
        chk("wrap2.sum",   64'(s8), 64'hFF);
        chk("wrap2.carry", 64'(c8), 64'd1);
        chk("wrap2.w16.sum", 64'(s16), 64'h01FF);

        // Reset colliding with a valid input: input discarded.
        drive(1'b1, 1'b1, 16'd1, 16'd1, 1'b0);
        tick;
        chk("coll.sum",   64'(s1), 64'd0);
        chk("coll.carry", 64'(c1), 64'd0);
        chk("coll.valid", 64'(v1), 64'd0);
        chk("coll.w16.sum", 64'(s16), 64'd0);

        // 1000 back-to-back random operands (checked by the model each cycle).
        for (int i = 0; i < 1000; i++) begin
            drive(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            tick;
        end

        // Mixed traffic: random gaps and occasional mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom));
            tick;
        end

        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        tick;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
